// File: rtl/reg_hilo_file.sv
// reg_hilo_file: architectural GPR file (32 x DATA_W) plus the HI/LO pair.
// WB writes commit on the rising clk edge. ID gets two combinational GPR
// read ports and EX gets the current HI/LO values.
// Optional feature: define REGFILE_WB_BYPASS_EN to forward same-cycle WB
// write data to the read outputs. Without it, reads return stored state only.
// rst is asynchronous and active-low. While it is low, all state clears and
// every read output is forced to zero.
module reg_hilo_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_reg_en,
    input  logic [ADDR_W-1:0] write_reg_addr,
    input  logic [DATA_W-1:0] write_reg_data,
    input  logic              write_hilo_en,
    input  logic [DATA_W-1:0] write_hi_data,
    input  logic [DATA_W-1:0] write_lo_data,
    input  logic              read_en_1,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic              read_en_2,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] hi_data,
    output logic [DATA_W-1:0] lo_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] gpr [DEPTH];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // A GPR write to address 0 is dropped, so GPR[0] holds zero from reset onward.
    wire gpr_wr = write_reg_en && (write_reg_addr != '0);

    // GPR storage: clear everything on reset, then take one WB write per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the whole array is cleared on reset because software
            // expects every GPR to read 0 after reset. This rules out a plain
            // RAM macro; the array is built from flops.
            for (int i = 0; i < DEPTH; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_wr) begin
            // NOTE: state is updated with non-blocking assignments, so every
            // reader in this time step sees the value from before the edge.
            gpr[write_reg_addr] <= write_reg_data;
        end
    end

    // HI/LO pair: both halves are always written together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (write_hilo_en) begin
            hi_q <= write_hi_data;
            lo_q <= write_lo_data;
        end
    end

    // Shared read-port rule: reset and address 0 force zero, then bypass, then storage.
    function automatic logic [DATA_W-1:0] gpr_read(input logic              en,
                                                   input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst && en && (addr != '0)) begin
            val = gpr[addr];
`ifdef REGFILE_WB_BYPASS_EN
            if (gpr_wr && (write_reg_addr == addr)) begin
                val = write_reg_data;
            end
`endif
        end
        return val;
    endfunction

    // Read port 1 (ID).
    always_comb begin
        read_data_1 = gpr_read(read_en_1, read_addr_1);
    end

    // Read port 2 (ID).
    always_comb begin
        read_data_2 = gpr_read(read_en_2, read_addr_2);
    end

    // HI/LO read port (EX): forced to zero in reset, with optional same-cycle forwarding.
    always_comb begin
        // NOTE: each output gets a default first, so no path through this
        // block can leave it unassigned and infer a latch.
        hi_data = '0;
        lo_data = '0;
        if (rst) begin
            hi_data = hi_q;
            lo_data = lo_q;
`ifdef REGFILE_WB_BYPASS_EN
            if (write_hilo_en) begin
                hi_data = write_hi_data;
                lo_data = write_lo_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_hilo_file.sv
// tb_reg_hilo_file: self-checking bench for reg_hilo_file.
// A behavioural model (array of GPRs plus HI/LO) predicts every read output.
// Directed scenarios run first, then a randomized stream with occasional resets.
// Build with REGFILE_WB_BYPASS_EN defined to check the forwarding variant.
module tb_reg_hilo_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              write_reg_en;
    logic [ADDR_W-1:0] write_reg_addr;
    logic [DATA_W-1:0] write_reg_data;
    logic              write_hilo_en;
    logic [DATA_W-1:0] write_hi_data;
    logic [DATA_W-1:0] write_lo_data;
    logic              read_en_1;
    logic [ADDR_W-1:0] read_addr_1;
    logic [DATA_W-1:0] read_data_1;
    logic              read_en_2;
    logic [ADDR_W-1:0] read_addr_2;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] hi_data;
    logic [DATA_W-1:0] lo_data;

    reg_hilo_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .write_reg_en  (write_reg_en),
        .write_reg_addr(write_reg_addr),
        .write_reg_data(write_reg_data),
        .write_hilo_en (write_hilo_en),
        .write_hi_data (write_hi_data),
        .write_lo_data (write_lo_data),
        .read_en_1     (read_en_1),
        .read_addr_1   (read_addr_1),
        .read_data_1   (read_data_1),
        .read_en_2     (read_en_2),
        .read_addr_2   (read_addr_2),
        .read_data_2   (read_data_2),
        .hi_data       (hi_data),
        .lo_data       (lo_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the architectural state.
    logic [DATA_W-1:0] m_gpr [32];
    logic [DATA_W-1:0] m_hi;
    logic [DATA_W-1:0] m_lo;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_hi = '0;
        m_lo = '0;
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic en, input logic [ADDR_W-1:0] a);
        if (!rst || !en || a == 0) return '0;
`ifdef REGFILE_WB_BYPASS_EN
        if (write_reg_en && write_reg_addr == a) return write_reg_data;
`endif
        return m_gpr[a];
    endfunction

    function automatic logic [DATA_W-1:0] exp_hi();
        if (!rst) return '0;
`ifdef REGFILE_WB_BYPASS_EN
        if (write_hilo_en) return write_hi_data;
`endif
        return m_hi;
    endfunction

    function automatic logic [DATA_W-1:0] exp_lo();
        if (!rst) return '0;
`ifdef REGFILE_WB_BYPASS_EN
        if (write_hilo_en) return write_lo_data;
`endif
        return m_lo;
    endfunction

    task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic he, input logic [DATA_W-1:0] hd, input logic [DATA_W-1:0] ld,
                         input logic e1, input logic [ADDR_W-1:0] a1,
                         input logic e2, input logic [ADDR_W-1:0] a2);
        write_reg_en   = we;
        write_reg_addr = wa;
        write_reg_data = wd;
        write_hilo_en  = he;
        write_hi_data  = hd;
        write_lo_data  = ld;
        read_en_1      = e1;
        read_addr_1    = a1;
        read_en_2      = e2;
        read_addr_2    = a2;
    endtask

    // Called just after a falling edge: check the pre-edge outputs, model the
    // rising edge, then return on the next falling edge.
    task automatic step();
        #1;
        check("rd1", read_data_1, exp_rd(read_en_1, read_addr_1));
        check("rd2", read_data_2, exp_rd(read_en_2, read_addr_2));
        check("hi", hi_data, exp_hi());
        check("lo", lo_data, exp_lo());
        @(posedge clk);
        if (rst) begin
            if (write_reg_en && write_reg_addr != 0) m_gpr[write_reg_addr] = write_reg_data;
            if (write_hilo_en) begin
                m_hi = write_hi_data;
                m_lo = write_lo_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a1, 1'b1, a2);
    endtask

    logic [DATA_W-1:0] same_exp;

    initial begin
        rst = 1'b0;
        model_clear();
        drive(1'b1, 5'd3, 32'hCAFE_0003, 1'b1, 32'h1, 32'h2, 1'b1, 5'd3, 1'b1, 5'd0);
        @(negedge clk);
        // Power-on reset: outputs zero, presented writes discarded.
        step();
        step();
        rst = 1'b1;
        idle_read(5'd3, 5'd3);
        step();

        // Fill GPR5 and HI, then reset: everything reads 0 immediately.
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b1, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1, 5'd5, 1'b0, 5'd0);
        step();
        idle_read(5'd5, 5'd5);
        #1 check("gpr5_filled", read_data_1, 32'h1234_5678);
        step();
        rst = 1'b0;
        model_clear();
        #1 check("rst_rd1_zero", read_data_1, '0);
        check("rst_hi_zero", hi_data, '0);
        step();
        rst = 1'b1;
        step();
        check("gpr5_after_rst", read_data_1, '0);
        check("hi_after_rst", hi_data, '0);

        // Write/readback on both ports, then disabled port reads 0.
        drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, 5'd7, 1'b0, 5'd7);
        step();
        idle_read(5'd7, 5'd7);
        #1 check("gpr7_p1", read_data_1, 32'hDEAD_BEEF);
        check("gpr7_p2", read_data_2, 32'hDEAD_BEEF);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd7, 1'b1, 5'd7);
        #1 check("rd1_disabled", read_data_1, '0);
        step();

        // Zero register ignores writes.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
        step();
        idle_read(5'd0, 5'd0);
        #1 check("r0_p1", read_data_1, '0);
        check("r0_p2", read_data_2, '0);
        step();

        // HI/LO together with a GPR write in the same cycle.
        drive(1'b1, 5'd3, 32'h55, 1'b1, 32'h0000_0001, 32'h8000_0000, 1'b0, '0, 1'b0, '0);
        step();
        idle_read(5'd3, 5'd0);
        #1 check("hi_wr", hi_data, 32'h1);
        check("lo_wr", lo_data, 32'h8000_0000);
        check("gpr3_wr", read_data_1, 32'h55);
        step();

        // Same-cycle read of a register being written.
        drive(1'b1, 5'd9, 32'h11, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b1, 5'd9, 32'h22, 1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd9);
`ifdef REGFILE_WB_BYPASS_EN
        same_exp = 32'h22;
`else
        same_exp = 32'h11;
`endif
        #1 check("same_cycle_pre", read_data_1, same_exp);
        step();
        idle_read(5'd9, 5'd9);
        #1 check("same_cycle_post", read_data_2, 32'h22);
        step();

        // Async reset falls between edges while a write to GPR4 is pending.
        drive(1'b1, 5'd4, 32'h99, 1'b0, '0, '0, 1'b1, 5'd4, 1'b0, '0);
        #2 rst = 1'b0;
        model_clear();
        #1 check("midrst_rd1", read_data_1, '0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        idle_read(5'd4, 5'd4);
        #1 check("gpr4_dropped", read_data_1, '0);
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h77, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        step();
        idle_read(5'd4, 5'd4);
        #1 check("gpr4_after", read_data_1, 32'h77);
        step();

        // Randomized traffic; addresses biased to a small window for read hits.
        for (int n = 0; n < 600; n++) begin
            logic [ADDR_W-1:0] wa, a1, a2;
            wa = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 7));
            a2 = ADDR_W'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                model_clear();
            end else begin
                rst = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), wa, DATA_W'($urandom),
                  1'($urandom_range(0, 3) == 0), DATA_W'($urandom), DATA_W'($urandom),
                  1'($urandom_range(0, 4) != 0), a1, 1'($urandom_range(0, 4) != 0), a2);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
